// File: rtl/iir_pkg.sv
// Shared constants and sample type for the IIR filter chain (filter, output buffer, data maker/sink).
package iir_pkg;
  localparam int IIR_DW            = 9;
  localparam int IIR_OUT_BUF_DEPTH = 8;

  typedef logic signed [IIR_DW-1:0] sample_t;

  localparam sample_t IIR_MOST_NEG = {1'b1, {(IIR_DW-1){1'b0}}};
endpackage

// File: rtl/iir_out_buffer_if.sv
// Producer/consumer signal bundle of the IIR output buffer.
// The peak port exists only when IIR_OUT_BUF_PEAK_EN is defined.
interface iir_out_buffer_if #(
  parameter int DW = 9,
  parameter int AW = 3
);
  logic [DW-1:0] din;
  logic          vin;
  logic          rdy;
  logic [DW-1:0] dout;
  logic          vout;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          ovf;
`ifdef IIR_OUT_BUF_PEAK_EN
  logic [DW-1:0] peak;

  modport master (output din, vin, rdy, input dout, vout, level, full, empty, ovf, peak);
  modport slave  (input din, vin, rdy, output dout, vout, level, full, empty, ovf, peak);
`else
  modport master (output din, vin, rdy, input dout, vout, level, full, empty, ovf);
  modport slave  (input din, vin, rdy, output dout, vout, level, full, empty, ovf);
`endif
endinterface

// File: rtl/iir_out_buffer_mem.sv
// DEPTH x DW storage for the output buffer: one write port, asynchronous read, no reset.
module iir_out_buffer_mem #(
  parameter int DW    = 9,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/iir_out_buffer.sv
// Circular FIFO between the non-stallable IIR filter and a valid/ready consumer.
// Optional running maximum of accepted samples: define IIR_OUT_BUF_PEAK_EN.
module iir_out_buffer
  import iir_pkg::*;
#(
  parameter int DW    = IIR_DW,
  parameter int DEPTH = IIR_OUT_BUF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  iir_out_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [AW:0]   level_q, level_nxt, level_after_pop;
  logic [DW-1:0] dout_q, rd_data;
  logic          vout_q, ovf_q;
  logic          push, pop, full, empty;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign pop   = vout_q & bus.rdy;
  assign push  = bus.vin & (~full | pop);

  // The output register looks at what remains after this edge's pop only,
  // so a sample written now becomes visible one cycle later (no bypass).
  always_comb begin
    rd_ptr_nxt      = rd_ptr;
    level_after_pop = level_q;
    if (pop) begin
      rd_ptr_nxt      = rd_ptr + AW'(1);
      level_after_pop = level_q - (AW+1)'(1);
    end
    level_nxt = level_after_pop;
    if (push) level_nxt = level_after_pop + (AW+1)'(1);
  end

  iir_out_buffer_mem #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (bus.din),
    .raddr (rd_ptr_nxt),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      vout_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr  <= rd_ptr_nxt;
      level_q <= level_nxt;
      if (bus.vin && full && !pop) ovf_q <= 1'b1;
      vout_q  <= (level_after_pop != '0);
      dout_q  <= (level_after_pop != '0) ? rd_data : '0;
    end
  end

  assign bus.dout  = dout_q;
  assign bus.vout  = vout_q;
  assign bus.level = level_q;
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.ovf   = ovf_q;

`ifdef IIR_OUT_BUF_PEAK_EN
  localparam logic [DW-1:0] PEAK_INIT = {1'b1, {(DW-1){1'b0}}};

  logic [DW-1:0] peak_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      peak_q <= PEAK_INIT;
    end else if (push && ($signed(bus.din) > $signed(peak_q))) begin
      peak_q <= bus.din;
    end
  end

  assign bus.peak = peak_q;
`endif
endmodule

// File: doc/iir_out_buffer.md
Name: iir_out_buffer

Overview:
- Downstream stage of the first-order IIR filter.
- Captures each valid 9-bit filtered sample (DIN qualified by VIN) into a small circular FIFO.
- Presents the samples to the consumer over a valid/ready handshake. This decouples the filter, which cannot be stalled, from a sink that may stall.
- Reports fill level and a sticky overflow flag.

Parameters:
DW, 9, sample width in bits (two's complement; matches filter DOUT)
DEPTH, 8, FIFO entries; power of two, minimum 2
AW, log2(DEPTH), pointer width (derived; not overridden)

Ports:
CLK  in  1  clock, all logic on rising edge
RST_n  in  1  reset: synchronous, active-low
DIN  in  DW  filtered sample from the IIR stage
VIN  in  1  DIN valid, single-cycle strobe per sample
RDY  in  1  consumer ready
DOUT  out  DW  head-of-FIFO sample
VOUT  out  1  DOUT valid
LEVEL  out  AW+1  number of stored entries, 0..DEPTH
FULL  out  1  LEVEL == DEPTH
EMPTY  out  1  LEVEL == 0
OVF  out  1  sticky overflow flag
PEAK  out  DW  only with IIR_OUT_BUF_PEAK_EN

Behaviour:
- Reset (RST_n low at a CLK edge):
  - Write/read pointers = 0, LEVEL = 0, EMPTY = 1, FULL = 0, OVF = 0, VOUT = 0, DOUT = 0.
  - Stored contents are discarded.
  - Reset mid-operation drops all queued samples; no output until new VIN.
- Push: VIN=1 and (FULL=0 or pop in the same cycle).
  - DIN is written at the write pointer.
  - The write pointer advances modulo DEPTH.
- Pop: VOUT=1 and RDY=1. The read pointer advances modulo DEPTH.
- LEVEL update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push+pop or on neither.
- Overflow: VIN=1, FULL=1, no pop in the same cycle.
  - The sample is dropped.
  - Pointers and LEVEL are unchanged.
  - OVF is set and stays 1 until reset.
- Full with simultaneous pop: the push is accepted, LEVEL stays DEPTH, OVF is unaffected.
- Empty with VIN=1 and RDY=1: no bypass. The sample is stored; VOUT rises on the next cycle.
- Output timing:
  - VOUT = not EMPTY, registered.
  - DOUT = entry at the read pointer, registered alongside VOUT.
  - DOUT = 0 whenever VOUT = 0.
- Latency: a sample pushed into an empty FIFO at edge N is on DOUT with VOUT=1 after edge N+1.
- Holding: while VOUT=1 and RDY=0, DOUT and VOUT are held stable.
- Ordering: strict FIFO; no reordering or duplication.
- No arithmetic on samples; the data path is bit-exact.

Optional Feature:
Macro IIR_OUT_BUF_PEAK_EN.
- When defined:
  - PEAK port exists; reset value is the most negative DW value (-256 for DW=9).
  - On every accepted push, PEAK <= max(PEAK, DIN) using signed comparison.
  - Dropped (overflow) samples do not update PEAK.
- When undefined: PEAK port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package iir_pkg:
  - IIR_DW = 9 and the signed sample typedef, shared with the filter and data_maker/data_sink.
  - Default DEPTH constant.
  - Most-negative-sample constant.
- One sub-module, iir_out_buffer_mem: DEPTH x DW register array.
  - Single write port with enable.
  - Asynchronous read by address.
  - No reset on storage.
- Pointer, level and flag logic live in the top module.

Test Plan:
- Reset then idle: RST_n low 3 cycles -> LEVEL=0, EMPTY=1, VOUT=0, DOUT=0, OVF=0; with PEAK enabled, PEAK=-256.
- Single sample: DIN=+37 with VIN for 1 cycle, RDY=1 -> next cycle VOUT=1 and DOUT=37; cycle after, VOUT=0 and LEVEL=0.
- Backpressure fill: RDY=0, push 8 samples 1..8 -> FULL=1, LEVEL=8, DOUT=1 held. Then RDY=1 -> outputs 1..8 in order on consecutive cycles, then EMPTY=1.
- Overflow: full with RDY=0, push -5 -> LEVEL stays 8, OVF=1; the drained sequence excludes -5. OVF stays 1 after draining until reset.
- Full plus simultaneous push/pop: full, RDY=1, VIN=1 with DIN=100 -> LEVEL stays 8, OVF=0; 100 emerges after the 8 earlier samples.
- Reset mid-stream and PEAK: push -256, 255, -1, then assert RST_n low with 3 queued -> EMPTY=1 next cycle. With macro, PEAK=255 before reset and -256 after.
